// File: rtl/ascon_pack.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_pack
//  Description : Shared types and constants for the Ascon permutation
//                controller (FSM state encoding and round index limits).
//  Revision    : 1.0 - initial release
// ============================================================================
package ascon_pack;

    // Controller state encoding
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_INIT    = 4'd1,
        ST_WAIT_AD = 4'd2,
        ST_AD      = 4'd3,
        ST_WAIT_PT = 4'd4,
        ST_PT      = 4'd5,
        ST_FINAL   = 4'd6,
        ST_TAG     = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    // Round index limits: 12-round permutation starts at 0, 6-round at 6
    localparam logic [3:0] ROUND_A_FIRST = 4'd0;
    localparam logic [3:0] ROUND_B_FIRST = 4'd6;
    localparam logic [3:0] ROUND_LAST    = 4'd11;

endpackage
`default_nettype wire

// File: rtl/ascon_fsm_ctrl_round_counter.sv
`default_nettype none
// ============================================================================
//  Module      : round_counter
//  Description : 4-bit constant-addition round index. Loads the first round
//                of a 12-round (a) or 6-round (b) permutation, otherwise
//                increments when enabled and holds when idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic       init_a_i,
    input  logic       init_b_i,
    output logic [3:0] round_o
);

    logic [3:0] r_round_q;
    logic [3:0] w_round_d;

    // Next round: loads take priority over the increment
    always_comb begin
        w_round_d = r_round_q;
        if (init_a_i) begin
            w_round_d = ROUND_A_FIRST;
        end else if (init_b_i) begin
            w_round_d = ROUND_B_FIRST;
        end else if (en_i) begin
            w_round_d = r_round_q + 4'd1;
        end
    end

    // Round register, cleared asynchronously
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_round_q <= ROUND_A_FIRST;
        end else begin
            r_round_q <= w_round_d;
        end
    end

    assign round_o = r_round_q;

endmodule
`default_nettype wire

// File: rtl/ascon_fsm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_fsm_ctrl
//  Description : Moore controller sequencing the Ascon permutation datapath
//                through initialisation, one associated-data block,
//                NB_BLOCKS_g plaintext blocks, finalisation and tag output.
//  Revision    : 1.0 - initial release
// ============================================================================
module ascon_fsm_ctrl
    import ascon_pack::*;
#(
    parameter int NB_BLOCKS_g = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    output logic       sel_o,
    output logic       en_state_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_o,
    output logic       en_xor_key_final_o,
    output logic       en_xor_lsb_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic [3:0] round_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic       end_o
);

    // Index of the last plaintext block; that block is absorbed by FINAL
    localparam logic [3:0] c_BLK_LAST = 4'(NB_BLOCKS_g - 1);

    state_t     r_state_q;
    state_t     w_state_d;
    logic [3:0] r_blk_q;
    logic [3:0] w_blk_d;
    logic [3:0] w_round;
    logic       w_cnt_en;
    logic       w_init_a;
    logic       w_init_b;
    logic       w_last;

    assign w_last = (w_round == ROUND_LAST);

    round_counter u_round_counter (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .en_i     (w_cnt_en),
        .init_a_i (w_init_a),
        .init_b_i (w_init_b),
        .round_o  (w_round)
    );

    // Next state, block count and round-counter control
    always_comb begin
        w_state_d = r_state_q;
        w_blk_d   = r_blk_q;
        w_cnt_en  = 1'b0;
        w_init_a  = 1'b0;
        w_init_b  = 1'b0;
        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_state_d = ST_INIT;
                    w_init_a  = 1'b1;
                    w_blk_d   = 4'd0;
                end
            end
            ST_INIT: begin
                if (w_last) w_state_d = ST_WAIT_AD;
                else        w_cnt_en  = 1'b1;
            end
            ST_WAIT_AD: begin
                if (data_valid_i) begin
                    w_state_d = ST_AD;
                    w_init_b  = 1'b1;
                end
            end
            ST_AD: begin
                if (w_last) w_state_d = ST_WAIT_PT;
                else        w_cnt_en  = 1'b1;
            end
            ST_WAIT_PT: begin
                if (data_valid_i) begin
                    if (r_blk_q < c_BLK_LAST) begin
                        w_state_d = ST_PT;
                        w_init_b  = 1'b1;
                    end else begin
                        w_state_d = ST_FINAL;
                        w_init_a  = 1'b1;
                    end
                end
            end
            ST_PT: begin
                if (w_last) begin
                    w_state_d = ST_WAIT_PT;
                    if (r_blk_q < c_BLK_LAST) w_blk_d = r_blk_q + 4'd1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_FINAL: begin
                if (w_last) w_state_d = ST_TAG;
                else        w_cnt_en  = 1'b1;
            end
            ST_TAG: begin
                w_state_d = ST_DONE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State and block-count registers, cleared asynchronously
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state_q <= ST_IDLE;
            r_blk_q   <= 4'd0;
        end else begin
            r_state_q <= w_state_d;
            r_blk_q   <= w_blk_d;
        end
    end

    // Moore output decode from registered state and round index
    always_comb begin
        sel_o              = 1'b0;
        en_state_o         = 1'b0;
        en_xor_data_o      = 1'b0;
        en_xor_key_o       = 1'b0;
        en_xor_key_final_o = 1'b0;
        en_xor_lsb_o       = 1'b0;
        en_cipher_o        = 1'b0;
        en_tag_o           = 1'b0;
        cipher_valid_o     = 1'b0;
        tag_valid_o        = 1'b0;
        end_o              = 1'b0;
        case (r_state_q)
            ST_INIT: begin
                en_state_o         = 1'b1;
                sel_o              = (w_round != ROUND_A_FIRST);
                en_xor_key_final_o = w_last;
            end
            ST_AD: begin
                en_state_o    = 1'b1;
                sel_o         = 1'b1;
                en_xor_data_o = (w_round == ROUND_B_FIRST);
                en_xor_lsb_o  = w_last;
            end
            ST_PT: begin
                en_state_o     = 1'b1;
                sel_o          = 1'b1;
                en_xor_data_o  = (w_round == ROUND_B_FIRST);
                en_cipher_o    = (w_round == ROUND_B_FIRST);
                // cipher register was loaded on the previous round
                cipher_valid_o = (w_round == ROUND_B_FIRST + 4'd1);
            end
            ST_FINAL: begin
                en_state_o         = 1'b1;
                sel_o              = (w_round != ROUND_A_FIRST);
                en_xor_data_o      = (w_round == ROUND_A_FIRST);
                en_xor_key_o       = (w_round == ROUND_A_FIRST);
                en_cipher_o        = (w_round == ROUND_A_FIRST);
                en_xor_key_final_o = w_last;
                cipher_valid_o     = (w_round == ROUND_A_FIRST + 4'd1);
            end
            ST_TAG: begin
                en_tag_o = 1'b1;
            end
            ST_DONE: begin
                tag_valid_o = 1'b1;
                end_o       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign round_o = w_round;

endmodule
`default_nettype wire

// File: tb/tb_ascon_fsm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ascon_fsm_ctrl
//  Description : Self-checking bench for ascon_fsm_ctrl. A phase/step model
//                predicts every output each cycle; directed checks pin
//                individual rounds, counts and the asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_fsm_ctrl;

    localparam int NB = 4;

    localparam int P_IDLE = 0, P_INIT = 1, P_WAD = 2, P_AD = 3, P_WPT = 4,
                   P_PT = 5, P_FIN = 6, P_TAG = 7, P_DONE = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       dv    = 1'b0;
    logic       sel_o, en_state_o, en_xor_data_o, en_xor_key_o;
    logic       en_xor_key_final_o, en_xor_lsb_o, en_cipher_o, en_tag_o;
    logic [3:0] round_o;
    logic       cipher_valid_o, tag_valid_o, end_o;
    logic [14:0] dut_vec;

    int n_total = 0;
    int n_bad   = 0;
    bit cmp_en  = 1'b0;

    ascon_fsm_ctrl #(.NB_BLOCKS_g(NB)) dut (
        .clock_i            (clock),
        .reset_i            (reset),
        .start_i            (start),
        .data_valid_i       (dv),
        .sel_o              (sel_o),
        .en_state_o         (en_state_o),
        .en_xor_data_o      (en_xor_data_o),
        .en_xor_key_o       (en_xor_key_o),
        .en_xor_key_final_o (en_xor_key_final_o),
        .en_xor_lsb_o       (en_xor_lsb_o),
        .en_cipher_o        (en_cipher_o),
        .en_tag_o           (en_tag_o),
        .round_o            (round_o),
        .cipher_valid_o     (cipher_valid_o),
        .tag_valid_o        (tag_valid_o),
        .end_o              (end_o)
    );

    assign dut_vec = {sel_o, en_state_o, en_xor_data_o, en_xor_key_o,
                      en_xor_key_final_o, en_xor_lsb_o, en_cipher_o, en_tag_o,
                      round_o, cipher_valid_o, tag_valid_o, end_o};

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase plus step-within-phase; rounds follow from phase start + step.
    int m_ph = P_IDLE, m_k = 0, m_blk = 0, m_held = 0;
    bit m_prev_cipher = 1'b0;
    logic [14:0] m_cur;

    function automatic logic [14:0] model_out();
        int r;
        bit act, sel, xd, xk, xkf, lsb, cip;
        act = (m_ph == P_INIT) || (m_ph == P_AD) || (m_ph == P_PT) || (m_ph == P_FIN);
        if (m_ph == P_INIT || m_ph == P_FIN)    r = m_k;
        else if (m_ph == P_AD || m_ph == P_PT)  r = 6 + m_k;
        else                                     r = m_held;
        sel = act && (r != 0);
        xd  = ((m_ph == P_AD || m_ph == P_PT) && r == 6) || (m_ph == P_FIN && r == 0);
        xk  = (m_ph == P_FIN && r == 0);
        xkf = (m_ph == P_INIT || m_ph == P_FIN) && r == 11;
        lsb = (m_ph == P_AD && r == 11);
        cip = (m_ph == P_PT && r == 6) || (m_ph == P_FIN && r == 0);
        return {sel, act, xd, xk, xkf, lsb, cip, (m_ph == P_TAG), 4'(r),
                m_prev_cipher, (m_ph == P_DONE), (m_ph == P_DONE)};
    endfunction

    // Model advance on each clock, cleared immediately by reset
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ph = P_IDLE; m_k = 0; m_blk = 0; m_held = 0; m_prev_cipher = 1'b0;
        end else begin
            m_cur = model_out();
            m_prev_cipher = m_cur[8];
            if (m_cur[13]) m_held = int'(m_cur[6:3]);
            case (m_ph)
                P_IDLE, P_DONE: if (start) begin m_ph = P_INIT; m_k = 0; m_blk = 0; end
                P_INIT: begin m_k++; if (m_k == 12) begin m_ph = P_WAD; m_k = 0; end end
                P_WAD:  if (dv) begin m_ph = P_AD; m_k = 0; end
                P_AD:   begin m_k++; if (m_k == 6) begin m_ph = P_WPT; m_k = 0; end end
                P_WPT:  if (dv) begin m_ph = (m_blk < NB - 1) ? P_PT : P_FIN; m_k = 0; end
                P_PT:   begin m_k++; if (m_k == 6) begin m_ph = P_WPT; m_k = 0; m_blk++; end end
                P_FIN:  begin m_k++; if (m_k == 12) begin m_ph = P_TAG; m_k = 0; end end
                P_TAG:  m_ph = P_DONE;
                default: m_ph = P_IDLE;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (cmp_en) chk("cycle_outputs", 32'(dut_vec), 32'(model_out()));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_msg(input bit hold_start, output int busy, output int cvs,
                           output int tags, output bit ok);
        busy = 0; cvs = 0; tags = 0; ok = 1'b0;
        start = 1'b1;
        dv    = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!hold_start || m_ph == P_FIN || m_ph == P_TAG || m_ph == P_DONE) start = 1'b0;
            if (en_state_o || en_tag_o) busy++;
            if (cipher_valid_o) cvs++;
            if (en_tag_o) tags++;
            if (end_o) begin ok = 1'b1; break; end
        end
        start = 1'b0;
        dv    = 1'b0;
    endtask

    int busy, cvs, tags;
    bit ok;

    initial begin
        // Reset held with random inputs
        cmp_en = 1'b1;
        repeat (6) begin
            start = 1'($urandom);
            dv    = 1'($urandom);
            tick();
        end
        chk("rst_round", 32'(round_o), 0);
        chk("rst_outputs", 32'(dut_vec), 0);
        start = 1'b0; dv = 1'b0;
        #2 reset = 1'b0;
        tick(); tick();

        // Initialisation: rounds 0..11 then idle wait for AD
        start = 1'b1; tick(); start = 1'b0;
        chk("init_r0_round", 32'(round_o), 0);
        chk("init_r0_sel", 32'(sel_o), 0);
        chk("init_r0_state", 32'(en_state_o), 1);
        tick();
        chk("init_r1_sel", 32'(sel_o), 1);
        repeat (10) tick();
        chk("init_r11_round", 32'(round_o), 11);
        chk("init_r11_keyfinal", 32'(en_xor_key_final_o), 1);
        repeat (5) begin tick(); chk("wait_ad_state", 32'(en_state_o), 0); end
        chk("wait_ad_round_hold", 32'(round_o), 11);

        // Associated data block
        dv = 1'b1; tick(); dv = 1'b0;
        chk("ad_r6_round", 32'(round_o), 6);
        chk("ad_r6_xor_data", 32'(en_xor_data_o), 1);
        chk("ad_r6_lsb", 32'(en_xor_lsb_o), 0);
        repeat (5) tick();
        chk("ad_r11_round", 32'(round_o), 11);
        chk("ad_r11_lsb", 32'(en_xor_lsb_o), 1);
        repeat (3) begin tick(); chk("wait_pt_state", 32'(en_state_o), 0); end

        // Finish the message: 3 PT blocks + FINAL, 4 cipher pulses
        dv = 1'b1; cvs = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cipher_valid_o) cvs++;
            if (end_o) begin ok = 1'b1; break; end
        end
        dv = 1'b0;
        chk("msg1_done", 32'(ok), 1);
        chk("msg1_cipher_pulses", 32'(cvs), 4);

        // Full message with data always valid, start held through PT
        run_msg(1'b1, busy, cvs, tags, ok);
        chk("msg2_done", 32'(ok), 1);
        chk("msg2_busy", 32'(busy), 49);
        chk("msg2_cipher_pulses", 32'(cvs), 4);
        chk("msg2_tag_cycles", 32'(tags), 1);
        repeat (3) tick();
        chk("done_hold_tag_valid", 32'(tag_valid_o), 1);
        chk("done_hold_end", 32'(end_o), 1);

        // Asynchronous reset at FINAL round 5
        start = 1'b1; dv = 1'b1; tick(); start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_ph == P_FIN && m_k == 5) begin ok = 1'b1; break; end
            tick();
        end
        chk("reach_final_r5", 32'(ok), 1);
        chk("final_r5_round", 32'(round_o), 5);
        chk("final_r5_state", 32'(en_state_o), 1);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_outputs", 32'(dut_vec), 0);
        chk("async_rst_round", 32'(round_o), 0);
        dv = 1'b0;
        tick(); tick();
        #2 reset = 1'b0;
        tick();
        chk("post_rst_idle", 32'(en_state_o), 0);

        // Fresh message reproduces the full sequence
        run_msg(1'b0, busy, cvs, tags, ok);
        chk("msg3_done", 32'(ok), 1);
        chk("msg3_busy", 32'(busy), 49);
        chk("msg3_cipher_pulses", 32'(cvs), 4);
        chk("msg3_tag_cycles", 32'(tags), 1);
        tick();

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
